game_ctrl_fsm: RTL
==================

// Module: game_ctrl_fsm
// PURPOSE
//   Top-level game controller for whack-a-mole; directly upstream of the countdown timer.
//   Drives the 2-bit game state consumed by the timer and reads back its BCD digits
//   (time_shi/time_ge). Counts player hits as a 2-digit BCD score.
//   Declares WIN when the score reaches the target, or LOSE when time reaches 00 first.
// PARAMETERS
//   TARGET_SHI  4'd2  BCD tens digit of the winning score (0-9)
//   TARGET_GE   4'd0  BCD units digit of the winning score (0-9); target 00 is illegal
// PORTS
//   clk_1      in   1  block clock; all state changes on its rising edge
//   rst        in   1  reset, asynchronous, active-high
//   start      in   1  start/restart button level, synchronous to clk_1
//   hit        in   1  one-cycle pulse: a mole was hit this cycle
//   miss       in   1  one-cycle pulse: an empty hole was struck (used only with PENALTY_EN)
//   time_shi   in   4  BCD tens of remaining time, from the timer
//   time_ge    in   4  BCD units of remaining time, from the timer
//   state      out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE (registered)
//   score_shi  out  4  BCD tens of score (registered)
//   score_ge   out  4  BCD units of score (registered)
//   game_over  out  1  = state[1]; high in WIN and LOSE
// BEHAVIOUR
//   - Reset: state=00, score=00, start_d=1.
//     start_d=1 ensures a button held through reset does not start a game.
//   - start_rise = start & ~start_d. start_d <= start every cycle.
//   - IDLE (00): score held at 00. start_rise -> PLAY; score cleared to 00 on the same edge.
//   - PLAY (01), evaluated each edge:
//       - hit: score increments as BCD (ge 9 -> 0 with shi+1); saturates at 99.
//       - If the post-update score >= {TARGET_SHI,TARGET_GE}: -> WIN on the same edge
//         (BCD compare: tens first, then units).
//       - Else if time_shi==0 && time_ge==0: -> LOSE.
//       - A hit that reaches the target in the same cycle as time 00 gives WIN
//         (score takes priority).
//       - start_rise is ignored in PLAY.
//   - WIN (10) / LOSE (11): score frozen; hit and miss ignored. start_rise -> IDLE.
//   - Timer interaction: the timer holds 40 while in IDLE, so entering PLAY never sees 00.
//     The timer reacts to a new state one clk_1 edge later.
//   - rst asserted mid-game: immediate return to IDLE, score 00, no partial-game retention.
//   - Illegal time digits (>9) are treated as nonzero; no special handling.
// CONFIGURATION
//   PENALTY_EN defined:
//     - In PLAY, miss decrements score as BCD (ge 0 -> 9 with shi-1), saturating at 00.
//     - hit and miss in the same cycle cancel: score unchanged.
//     - The target check uses the post-update score.
//   PENALTY_EN undefined: miss is ignored entirely and score never decreases.
// TESTING
//   1. rst pulse with start held high, then release -> state stays 00, score 00;
//      drop and raise start -> state 01.
//   2. PLAY, 20 hit pulses, time held at 35 -> score 20, state 10 on the 20th hit's edge;
//      further hits leave score at 20.
//   3. PLAY, 5 hits, then time driven to 00 -> state 11, score 05, game_over=1;
//      start_rise -> state 00.
//   4. PLAY, score 19, hit in the same cycle time=00 -> state 10, score 20.
//   5. PLAY, score 09, hit -> score 10 (BCD carry); TARGET=99 with 99 hits -> saturate at 99, WIN.
//   6. PENALTY_EN: score 10, miss -> 09; score 00, miss -> 00; hit+miss together -> unchanged.
//      Without the macro, miss has no effect.

Source files
------------

// File: rtl/game_ctrl_fsm.sv
// Whack-a-mole game controller: drives IDLE/PLAY/WIN/LOSE and keeps a BCD score.
// Optional PENALTY_EN macro: a miss in PLAY decrements the score (saturating at 00).
module game_ctrl_fsm #(
    parameter logic [3:0] TARGET_SHI = 4'd2,
    parameter logic [3:0] TARGET_GE  = 4'd0
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic [3:0] time_shi,
    input  logic [3:0] time_ge,
    output logic [1:0] state,
    output logic [3:0] score_shi,
    output logic [3:0] score_ge,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10,
        S_LOSE = 2'b11
    } st_t;

    st_t        state_q, state_d;
    logic [3:0] shi_q, ge_q, shi_d, ge_d;
    logic [3:0] inc_shi, inc_ge, dec_shi, dec_ge;
    logic [3:0] upd_shi, upd_ge;
    logic       start_d, start_rise;
    logic       up, dn;
    logic       reach, time_zero;

    assign start_rise = start & ~start_d;
    assign time_zero  = (time_shi == 4'd0) && (time_ge == 4'd0);

`ifdef PENALTY_EN
    // A simultaneous hit and miss cancel out.
    assign up = hit & ~miss;
    assign dn = miss & ~hit;
`else
    logic unused_miss;
    assign unused_miss = miss;
    assign up = hit;
    assign dn = 1'b0;
`endif

    // BCD increment/decrement of the current score, saturating at 99 / 00.
    always_comb begin
        inc_shi = shi_q;
        inc_ge  = ge_q;
        dec_shi = shi_q;
        dec_ge  = ge_q;
        if (!(shi_q == 4'd9 && ge_q == 4'd9)) begin
            if (ge_q == 4'd9) begin
                inc_shi = shi_q + 4'd1;
                inc_ge  = 4'd0;
            end else begin
                inc_ge = ge_q + 4'd1;
            end
        end
        if (!(shi_q == 4'd0 && ge_q == 4'd0)) begin
            if (ge_q == 4'd0) begin
                dec_shi = shi_q - 4'd1;
                dec_ge  = 4'd9;
            end else begin
                dec_ge = ge_q - 4'd1;
            end
        end
        upd_shi = shi_q;
        upd_ge  = ge_q;
        if (up) begin
            upd_shi = inc_shi;
            upd_ge  = inc_ge;
        end else if (dn) begin
            upd_shi = dec_shi;
            upd_ge  = dec_ge;
        end
        reach = (upd_shi > TARGET_SHI) ||
                ((upd_shi == TARGET_SHI) && (upd_ge >= TARGET_GE));
    end

    // State, score and start-edge registers; start_d resets high so a
    // button held through reset does not start a game.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shi_q   <= 4'd0;
            ge_q    <= 4'd0;
            start_d <= 1'b1;
        end else begin
            state_q <= state_d;
            shi_q   <= shi_d;
            ge_q    <= ge_d;
            start_d <= start;
        end
    end

    // Next state and next score; score beats timeout when both occur.
    always_comb begin
        state_d = state_q;
        shi_d   = shi_q;
        ge_d    = ge_q;
        unique case (state_q)
            S_IDLE: begin
                shi_d = 4'd0;
                ge_d  = 4'd0;
                if (start_rise) state_d = S_PLAY;
            end
            S_PLAY: begin
                shi_d = upd_shi;
                ge_d  = upd_ge;
                if (reach)          state_d = S_WIN;
                else if (time_zero) state_d = S_LOSE;
            end
            S_WIN, S_LOSE: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    shi_d   = 4'd0;
                    ge_d    = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs straight from the registers.
    always_comb begin
        state     = state_q;
        score_shi = shi_q;
        score_ge  = ge_q;
        game_over = state_q[1];
    end

endmodule
